// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    // Controller states
    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        ISSUE,
        READ_WAIT,
        RESP
    } arb_state_t;

    // Requester ids: M0 = load/store unit, M1 = debug/program loader
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the last-grant history lives in the parent.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_id
);

    // A lone requester wins; on a tie the one not granted last time wins
    always_comb begin
        gnt_id = M0;
        if (req == 2'b11) begin
            gnt_id = ~last_gnt;
        end else if (req[1]) begin
            gnt_id = M1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single data port of the unified instruction/data memory between
// the load/store unit (M0) and the debug/program loader (M1).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_be,
    output logic              m0_done,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_be,
    output logic              m1_done,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,

    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,

    output logic              busy
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t        state;
    logic              last_gnt;
    logic              cur_id;
    logic              cur_we;
    logic              timed_out;
    logic [CNT_W-1:0]  wait_cnt;

    logic [1:0]        req_vec;
    logic              gnt_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_be;
    logic              sel_in_range;

    logic              rd_capture;
    logic              rd_timeout;

    logic              rsp_fire;
    logic              rsp_id;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;

    assign req_vec = {m1_req, m0_req};

    rr_arb2 u_rr_arb2 (
        .req      (req_vec),
        .last_gnt (last_gnt),
        .gnt_id   (gnt_id)
    );

    // Route the winning requester's command fields and range-check its address
    always_comb begin
        if (gnt_id == M1) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
            sel_be    = m1_be;
        end else begin
            sel_we    = m0_we;
            sel_addr  = m0_addr;
            sel_wdata = m0_wdata;
            sel_be    = m0_be;
        end
        sel_in_range = (32'(sel_addr) < 32'(MEM_WORDS));
    end

    // Read-wait exits: ready is ignored in the first wait cycle (count 0)
    always_comb begin
        rd_capture = (state == READ_WAIT) && (wait_cnt != '0) && mem_ready;
        rd_timeout = (state == READ_WAIT) && !rd_capture && (wait_cnt == CNT_LAST);
    end

    // Decode the cycle in which a completion is produced for the current owner
    always_comb begin
        rsp_fire  = 1'b0;
        rsp_id    = cur_id;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        unique case (state)
            IDLE: begin
                if ((req_vec != 2'b00) && !sel_in_range) begin
                    rsp_fire = 1'b1;
                    rsp_id   = gnt_id;
                    rsp_err  = 1'b1;
                end
            end
            ISSUE: begin
                if (cur_we) begin
                    rsp_fire = 1'b1;
                end
            end
            READ_WAIT: begin
                if (rd_capture) begin
                    rsp_fire  = 1'b1;
                    rsp_rdata = mem_rdata;
                end else if (rd_timeout) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control FSM: arbitration, one-cycle memory strobes, read timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SYNC;
            last_gnt  <= M1;
            cur_id    <= M0;
            cur_we    <= 1'b0;
            timed_out <= 1'b0;
            wait_cnt  <= '0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            busy      <= 1'b0;
        end else begin
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            unique case (state)
                SYNC: begin
                    if (mem_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        busy  <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_vec != 2'b00) begin
                        cur_id   <= gnt_id;
                        cur_we   <= sel_we;
                        last_gnt <= gnt_id;
                        busy     <= 1'b1;
                        if (sel_in_range) begin
                            mem_ren   <= ~sel_we;
                            mem_wen   <= sel_we;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                            mem_be    <= sel_be;
                            state     <= ISSUE;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= cur_we ? RESP : READ_WAIT;
                end
                READ_WAIT: begin
                    if (rd_capture) begin
                        wait_cnt <= '0;
                        state    <= RESP;
                    end else if (rd_timeout) begin
                        wait_cnt  <= '0;
                        timed_out <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (timed_out) begin
                        timed_out <= 1'b0;
                        state     <= SYNC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= SYNC;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Requester-side completion registers; data and error hold until the next done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_done  <= 1'b0;
            m0_rdata <= '0;
            m0_err   <= 1'b0;
            m1_done  <= 1'b0;
            m1_rdata <= '0;
            m1_err   <= 1'b0;
        end else begin
            m0_done <= rsp_fire && (rsp_id == M0);
            m1_done <= rsp_fire && (rsp_id == M1);
            if (rsp_fire && (rsp_id == M0)) begin
                m0_rdata <= rsp_rdata;
                m0_err   <= rsp_err;
            end
            if (rsp_fire && (rsp_id == M1)) begin
                m1_rdata <= rsp_rdata;
                m1_err   <= rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter with a latency-accurate memory model.
module tb_mem_arbiter;

    localparam int AW = 11;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic [3:0]    m0_be, m1_be;
    logic          m0_done, m0_err, m1_done, m1_err;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          mem_ren, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata = '0;
    logic          mem_ready = 1'b1;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    bit hang     = 1'b0;
    bit last_srv = 1'b1;

    logic [31:0] ref_mem [0:2047];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .MEM_WORDS(1024), .TIMEOUT_CYC(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0003);
    endfunction

    // Memory model: ready drops after a read strobe and returns 7 cycles later
    logic [31:0]   mem [0:2047];
    logic          mem_init = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    int            lat = 0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
            mem_init <= 1'b1;
        end else begin
            if (mem_wen)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_ren) begin
                mem_ready <= 1'b0;
                lat       <= 6;
                pend_addr <= mem_addr;
            end else if (!mem_ready) begin
                if (lat != 0) lat <= lat - 1;
                else if (!hang) begin
                    mem_ready <= 1'b1;
                    mem_rdata <= mem[pend_addr];
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input int p);
        return (p == 1) ? m1_done : m0_done;
    endfunction
    function automatic logic [31:0] rdata_of(input int p);
        return (p == 1) ? m1_rdata : m0_rdata;
    endfunction
    function automatic logic err_of(input int p);
        return (p == 1) ? m1_err : m0_err;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic set_req(input int p, input bit v, input txn_t t);
        if (p == 0) begin
            m0_req = v; m0_we = t.we; m0_addr = t.addr; m0_wdata = t.wdata; m0_be = t.be;
        end else begin
            m1_req = v; m1_we = t.we; m1_addr = t.addr; m1_wdata = t.wdata; m1_be = t.be;
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = ($urandom_range(0, 7) == 0) ? AW'(1024 + $urandom_range(0, 1023))
                                               : AW'($urandom_range(0, 15));
        t.wdata = $urandom;
        t.be    = 4'($urandom_range(0, 15));
        return t;
    endfunction

    // Issue one or two simultaneous requests; served order follows round-robin
    task automatic do_txn(input bit r0, input bit r1, input txn_t t0, input txn_t t1);
        int order[$];
        if (r0 && r1) order = (last_srv == 1'b1) ? '{0, 1} : '{1, 0};
        else if (r0)  order = '{0};
        else          order = '{1};
        if (r0) set_req(0, 1'b1, t0);
        if (r1) set_req(1, 1'b1, t1);
        for (int s = 0; s < order.size(); s++) begin
            int          p;
            txn_t        t;
            int          k, lat_c, d;
            bit          inr;
            logic [31:0] exp_rd;
            p      = order[s];
            t      = (p == 1) ? t1 : t0;
            k      = (s == 0) ? 1 : 2;
            inr    = int'(t.addr) < 1024;
            lat_c  = !inr ? 1 : (t.we ? 2 : 10);
            d      = k - 1 + lat_c;
            exp_rd = (inr && !t.we) ? ref_mem[t.addr] : 32'h0;
            last_srv = p[0];
            for (int n = 1; n <= d; n++) begin
                tick();
                chk("mem_ren", mem_ren, (n == k && inr && !t.we));
                chk("mem_wen", mem_wen, (n == k && inr && t.we));
                if (n == k && inr) begin
                    chk("mem_addr", mem_addr, t.addr);
                    if (t.we) begin
                        chk("mem_wdata", mem_wdata, t.wdata);
                        chk("mem_be", mem_be, t.be);
                    end
                end
                chk((p == 1) ? "m1_done" : "m0_done", done_of(p), (n == d));
                chk((p == 1) ? "m0_done_idle" : "m1_done_idle", done_of(1 - p), 1'b0);
            end
            if (!(inr && t.we)) chk((p == 1) ? "m1_rdata" : "m0_rdata", rdata_of(p), exp_rd);
            chk((p == 1) ? "m1_err" : "m0_err", err_of(p), !inr);
            if (inr && t.we) ref_mem[t.addr] = merge(ref_mem[t.addr], t.wdata, t.be);
            set_req(p, 1'b0, t);
        end
        tick();
    endtask

    // Read request already raised while the FSM waits in SYNC
    task automatic await_read(input int p, input logic [AW-1:0] a, input string tag);
        int n   = 0;
        int run = 0;
        bit seen = 1'b0;
        while (!seen && n < 60) begin
            tick();
            n++;
            run = mem_ready ? run + 1 : 0;
            if (mem_ren) seen = 1'b1;
            else chk({tag, "_early_done"}, done_of(p), 1'b0);
        end
        chk({tag, "_issued"}, seen, 1'b1);
        if (seen) begin
            chk({tag, "_sync_gap"}, run, 3);
            chk({tag, "_addr"}, mem_addr, a);
            for (int i = 1; i <= 9; i++) begin
                tick();
                chk({tag, "_done"}, done_of(p), (i == 9));
            end
            chk({tag, "_rdata"}, rdata_of(p), ref_mem[a]);
            chk({tag, "_err"}, err_of(p), 1'b0);
        end
        set_req(p, 1'b0, '0);
        last_srv = p[0];
        tick();
    endtask

    initial begin
        txn_t t0, t1, rd10;
        bit   ok;
        reset = 1'b0;
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
        for (int i = 0; i < 2048; i++) ref_mem[i] = pat(i);
        rd10 = '{1'b0, AW'(11'h010), 32'h0, 4'h0};

        tick(); tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_m0_done", m0_done, 1'b0);
        chk("rst_m1_done", m1_done, 1'b0);
        chk("rst_mem_ren", mem_ren, 1'b0);
        chk("rst_mem_wen", mem_wen, 1'b0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        reset = 1'b1;
        tick(); tick();
        chk("idle_busy", busy, 1'b0);

        // Simultaneous requests out of reset: M0 write first, then M1 reads it back
        t0 = '{1'b1, AW'(11'h010), 32'hDEADBEEF, 4'hF};
        do_txn(1'b1, 1'b1, t0, rd10);
        do_txn(1'b1, 1'b0, rd10, '0);
        do_txn(1'b0, 1'b1, '0, rd10);

        // Repeated ties alternate
        for (int i = 0; i < 3; i++) begin
            t0 = '{1'b0, AW'($urandom_range(0, 15)), 32'h0, 4'h0};
            t1 = '{1'b0, AW'($urandom_range(0, 15)), 32'h0, 4'h0};
            do_txn(1'b1, 1'b1, t0, t1);
        end

        // Out-of-range address and a partial byte-enable write
        do_txn(1'b1, 1'b0, '{1'b0, AW'(1024), 32'h0, 4'h0}, '0);
        do_txn(1'b0, 1'b1, '0, '{1'b1, AW'(3), 32'h1122_3344, 4'b0101});
        do_txn(1'b1, 1'b0, '{1'b0, AW'(3), 32'h0, 4'h0}, '0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int r;
            r  = $urandom_range(1, 3);
            t0 = rand_txn();
            t1 = rand_txn();
            do_txn(r[0], r[1], t0, t1);
        end

        // Hung read: abort after 32 wait cycles, then hold off until ready returns
        hang = 1'b1;
        set_req(0, 1'b1, '{1'b0, AW'(5), 32'h0, 4'h0});
        for (int n = 1; n <= 34; n++) begin
            tick();
            chk("to_mem_ren", mem_ren, (n == 1));
            chk("to_m0_done", m0_done, (n == 34));
        end
        chk("to_m0_err", m0_err, 1'b1);
        chk("to_m0_rdata", m0_rdata, 32'h0);
        set_req(0, 1'b0, '0);
        last_srv = 1'b0;
        set_req(1, 1'b1, rd10);
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("to_sync_ren", mem_ren, 1'b0);
            chk("to_sync_busy", busy, 1'b1);
            chk("to_sync_m1_done", m1_done, 1'b0);
        end
        hang = 1'b0;
        await_read(1, AW'(11'h010), "post_to");

        // Reset in the middle of a read
        set_req(0, 1'b1, rd10);
        for (int n = 1; n <= 4; n++) begin
            tick();
            if (n == 1) chk("rr_mem_ren", mem_ren, 1'b1);
        end
        reset = 1'b0;
        #1;
        ok = !m0_done && !m1_done && !m0_err && !m1_err && !mem_ren && !mem_wen && !busy;
        chk("rr_ctl_zero", ok, 1'b1);
        chk("rr_m0_rdata", m0_rdata, 32'h0);
        chk("rr_m1_rdata", m1_rdata, 32'h0);
        chk("rr_mem_addr", mem_addr, '0);
        chk("rr_mem_wdata", mem_wdata, 32'h0);
        chk("rr_mem_be", mem_be, 4'h0);
        set_req(0, 1'b0, '0);
        tick(); tick();
        reset    = 1'b1;
        last_srv = 1'b1;
        set_req(0, 1'b1, rd10);
        await_read(0, AW'(11'h010), "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester controller that shares the single data port of the unified instruction/data memory.
- Requester M0 is the core load/store unit; requester M1 is the debug/program loader.
- Owns arbitration, pulses the memory's ren/wen for exactly one cycle, tracks the multi-cycle read handshake on the memory ready line, and returns data to the winner with a one-cycle done pulse.
- Flags out-of-range addresses and hung reads as errors.

Parameters:
- ADDR_W, 10, word-address width on both requester ports and on the memory port.
- MEM_WORDS, 1024, number of implemented words; addresses >= MEM_WORDS are out of range.
- TIMEOUT_CYC, 32, maximum READ_WAIT cycles before a read is aborted with error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- m0_req  in  1  M0 request; held with fields stable until m0_done.
- m0_we  in  1  M0 1=write, 0=read.
- m0_addr  in  ADDR_W  M0 word address.
- m0_wdata  in  32  M0 write data.
- m0_be  in  4  M0 byte enables; bit3 covers [31:24].
- m0_done  out  1  one-cycle completion pulse.
- m0_rdata  out  32  read data, valid during m0_done.
- m0_err  out  1  error, valid during m0_done.
- m1_*  same set, same widths and meaning, for M1.
- mem_ren  out  1  memory read strobe.
- mem_wen  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte select.
- mem_rdata  in  32  memory data_out.
- mem_ready  in  1  memory ready; low while a read is in flight.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0): all outputs 0. State=SYNC. last_gnt=1, so M0 wins the first tie. Timeout counter=0.
- SYNC: wait until mem_ready=1, then go to IDLE. This covers a reset that lands while a memory read is in flight; no request is accepted before that.
- IDLE: sample m0_req and m1_req.
  - Single requester: it wins.
  - Both requesting: round-robin, the winner is the one not equal to last_gnt.
  - Latch winner id, we, addr, wdata and be. Update last_gnt.
  - If addr >= MEM_WORDS: go to RESP with err=1 and rdata=0. No memory strobe is issued; done appears at t+1.
  - Otherwise: register mem_ren=~we, mem_wen=we, plus addr/wdata/be, and go to ISSUE.
- ISSUE (t+1): strobes are high for exactly this cycle. ren and wen are never both 1.
  - Write: go to RESP with err=0; m*_done at t+2.
  - Read: go to READ_WAIT.
- READ_WAIT:
  - Strobes are 0.
  - mem_ready is ignored in the first READ_WAIT cycle (the memory drives it low there).
  - Afterwards, mem_ready=1 captures mem_rdata and the FSM goes to RESP.
  - With the current memory: ready returns at t+9 and done at t+10.
  - The counter increments each cycle. When it reaches TIMEOUT_CYC: go to RESP with err=1, rdata=0, then go to SYNC instead of IDLE.
- RESP: winner's done=1 for one cycle with rdata and err; the loser's outputs stay 0. Next state is IDLE (or SYNC after a timeout). rdata and err hold their value until the next done for that port.
- Requests are sampled only in IDLE. A requester still asserting req in its done cycle starts a new transaction; requesters drop req in the done cycle.
- A request arriving in any non-IDLE state waits; it is never lost and never partially served.
- mem_addr/wdata/be keep their last value when strobes are 0.

Decomposition:
- mem_arb_pkg holds:
  - the state encoding: SYNC, IDLE, ISSUE, READ_WAIT, RESP;
  - requester id constants: M0=0, M1=1.
- One sub-module, rr_arb2: a 2-way round-robin picker with inputs req[1:0] and last_gnt, output gnt_id. It is combinational, and last_gnt is held in the parent.
- FSM, latches and timeout counter live in mem_arbiter.

Test Plan:
- M0 write, addr 0x010, wdata 0xDEADBEEF, be 4'b1111 at t -> mem_wen=1 only at t+1, m0_done at t+2, m0_err=0; a later M0 read of 0x010 returns 0xDEADBEEF.
- M1 read of 0x010 after that write -> mem_ren=1 for one cycle at t+1, m1_done at t+10 with m1_rdata=0xDEADBEEF; m0_done stays 0.
- Both request at once straight out of reset -> M0 served first, M1 next; repeated simultaneous requests alternate M0, M1, M0.
- M0 read of addr 1024 with MEM_WORDS=1024 -> no ren/wen, m0_done at t+1 with m0_err=1, m0_rdata=0.
- Memory model holds mem_ready low indefinitely -> done after 32 READ_WAIT cycles with err=1; FSM goes to SYNC and accepts a new request only after mem_ready=1.
- reset pulled to 0 at t+4 of a read -> outputs 0 immediately; FSM stays in SYNC until the memory reasserts ready; a following read of 0x010 completes correctly.
